// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction memory responder with loader write port
module imem_responder #(
   parameter int                ADDR_W      = 64,
   parameter int                DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
   parameter int                LATENCY     = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDR_W-1:0]              req_addr,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [31:0]                    resp_inst,
   output logic                           resp_err,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
   input  logic [31:0]                    ld_data,
   output logic [31:0]                    fetch_cnt
);

   localparam int              IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + ((ADDR_W+1)'(DEPTH_WORDS) << 2);
   localparam logic [31:0]     EBREAK   = 32'h0010_0073;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [31:0]       r_inst;
   logic              r_err;
   logic [31:0]       r_fetch_cnt;
   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_misaligned;
   logic              w_below;
   logic              w_above;
   logic              w_err;
   logic [IDX_W-1:0]  w_idx;
   logic              w_accept;
   logic              w_done;

   // Range check is done one bit wider so BASE_ADDR + size cannot wrap.
   assign w_misaligned = |req_addr[1:0];
   assign w_below      = req_addr < BASE_ADDR;
   assign w_above      = {1'b0, req_addr} >= END_ADDR;
   assign w_err        = w_misaligned || w_below || w_above;
   assign w_idx        = req_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
   assign w_accept     = req_valid && r_req_ready;
   assign w_done       = r_resp_valid && resp_ready;

   // Loader writes are independent of the FSM and of reset.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         r_mem[ld_idx] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_inst       <= 32'd0;
         r_err        <= 1'b0;
         r_fetch_cnt  <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_inst      <= w_err ? EBREAK : r_mem[w_idx];
                  r_err       <= w_err;
                  r_cnt       <= 4'(LATENCY - 1);
                  r_req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Leave when this decrement brings the counter to zero.
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
               end
            end
            S_RESP: begin
               if (w_done) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_inst  = r_inst;
   assign resp_err   = r_err;
   assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized model-checked bench for imem_responder
module tb_imem_responder;

   localparam int          L     = 2;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LIMIT = BASE + 64'd4096;
   localparam logic [31:0] EBRK  = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst, req_valid, resp_ready, ld_we;
   logic [63:0] req_addr;
   logic [9:0]  ld_idx;
   logic [31:0] ld_data;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_inst, fetch_cnt;

   logic        b_rst, b_req_valid, b_resp_ready;
   logic [63:0] b_req_addr;
   logic        b_req_ready, b_resp_valid, b_resp_err;
   logic [31:0] b_resp_inst, b_fetch_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imem_responder #(.ADDR_W(64), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(L)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
      .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data), .fetch_cnt(fetch_cnt)
   );

   imem_responder #(.ADDR_W(64), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_inst(b_resp_inst), .resp_err(b_resp_err),
      .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data), .fetch_cnt(b_fetch_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a response is owed from acceptance until handshake, and
   // becomes visible once LATENCY-1 further clock edges have passed.
   logic [31:0] m_mem [0:1023];
   bit          m_init = 0;
   bit          m_busy = 0;
   int unsigned m_cyc  = 0;
   int unsigned m_acc  = 0;
   logic [31:0] m_cnt  = 0;
   logic [31:0] m_inst = 0;
   logic        m_err  = 0;

   function automatic bit exp_rv();
      return m_busy && ((m_cyc - m_acc) >= (L - 1));
   endfunction

   function automatic bit addr_bad(input logic [63:0] a);
      return (a[1:0] != 2'b00) || (a < BASE) || (a >= LIMIT);
   endfunction

   always @(posedge clk) begin
      m_cyc <= m_cyc + 1;
      if (ld_we) m_mem[ld_idx] <= ld_data;
      if (!rst) begin
         m_init <= 1;
         m_busy <= 0;
         m_cnt  <= 0;
         m_inst <= 0;
         m_err  <= 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy <= 1;
            m_acc  <= m_cyc + 1;
            if (addr_bad(req_addr)) begin
               m_err  <= 1;
               m_inst <= EBRK;
            end else begin
               m_err  <= 0;
               m_inst <= m_mem[int'((req_addr - BASE) >> 2)];
            end
         end
      end else if (exp_rv() && resp_ready) begin
         m_busy <= 0;
         m_cnt  <= m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("m_req_ready", req_ready, !m_busy);
         chk("m_resp_valid", resp_valid, exp_rv());
         chk("m_fetch_cnt", fetch_cnt, m_cnt);
         chk("m_resp_inst", resp_inst, m_inst);
         chk("m_resp_err", resp_err, m_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic fetch_lit(input string nm, input logic [63:0] a, input logic [31:0] ei,
                            input logic ee, input logic [31:0] ec);
      int n;
      req_valid = 1; req_addr = a; resp_ready = 1;
      step();
      req_valid = 0; req_addr = {$urandom, $urandom};
      n = 1;
      while (!resp_valid && n < 20) begin
         step();
         n++;
      end
      chk({nm, "_lat"}, n, L);
      chk({nm, "_inst"}, resp_inst, ei);
      chk({nm, "_err"}, resp_err, ee);
      step();
      chk({nm, "_cnt"}, fetch_cnt, ec);
      chk({nm, "_idle"}, req_ready, 1);
   endtask

   task automatic wait_resp(input string nm);
      int n;
      n = 0;
      while (!resp_valid && n < 20) begin
         step();
         n++;
      end
      chk({nm, "_seen"}, resp_valid, 1);
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      ld_we = 1; ld_idx = 10'(idx); ld_data = d;
      step();
      ld_we = 0;
   endtask

   function automatic logic [63:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return BASE + 64'(4 * ($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, 1023)));
      if (r == 7) return BASE + 64'(4 * $urandom_range(0, 1023) + $urandom_range(1, 3));
      if (r == 8) return $urandom_range(0, 1) ? LIMIT + 64'(4 * $urandom_range(0, 63)) : BASE - 64'(4 * $urandom_range(1, 64));
      return {$urandom, $urandom};
   endfunction

   logic [31:0] b_lit [4];

   initial begin
      b_lit[0] = 32'h0000_0513; b_lit[1] = 32'h0010_0073;
      b_lit[2] = 32'h00A0_0593; b_lit[3] = 32'h0FF0_0613;
      rst = 0; b_rst = 0; req_valid = 0; resp_ready = 0; req_addr = BASE;
      ld_we = 0; ld_idx = 0; ld_data = 0;
      b_req_valid = 0; b_resp_ready = 0; b_req_addr = BASE;
      step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_fetch_cnt", fetch_cnt, 0);
      chk("rst_resp_inst", resp_inst, 0);
      chk("rst_resp_err", resp_err, 0);

      // Program image is loaded while both instances sit in reset.
      for (int i = 0; i < 1024; i++) load(i, $urandom);
      for (int i = 0; i < 4; i++) load(i, b_lit[i]);
      load(1023, 32'h1234_5678);

      b_rst = 1;
      step();
      for (int j = 0; j < 4; j++) begin
         b_req_addr = BASE + 64'(4 * j); b_req_valid = 1; b_resp_ready = 1;
         step();
         chk("l1_resp_valid", b_resp_valid, 1);
         chk("l1_resp_inst", b_resp_inst, b_lit[j]);
         chk("l1_resp_err", b_resp_err, 0);
         chk("l1_busy", b_req_ready, 0);
         step();
         chk("l1_idle_valid", b_resp_valid, 0);
         chk("l1_idle_ready", b_req_ready, 1);
         chk("l1_fetch_cnt", b_fetch_cnt, 32'(j + 1));
      end
      b_req_valid = 0;

      rst = 1;
      step();
      fetch_lit("ok0", BASE, 32'h0000_0513, 0, 1);
      fetch_lit("misal", BASE + 64'd2, EBRK, 1, 2);
      fetch_lit("past_end", 64'h8000_1000, EBRK, 1, 3);
      fetch_lit("below", 64'h7FFF_FFFC, EBRK, 1, 4);
      fetch_lit("last", 64'h8000_0FFC, 32'h1234_5678, 0, 5);
      fetch_lit("high32", 64'hFFFF_FFFF_8000_0000, EBRK, 1, 6);

      req_valid = 1; req_addr = BASE; resp_ready = 0;
      step();
      req_addr = BASE + 64'd4;
      wait_resp("bp");
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", resp_valid, 1);
         chk("bp_ready", req_ready, 0);
         chk("bp_inst", resp_inst, 32'h0000_0513);
         step();
      end
      resp_ready = 1;
      step();
      chk("bp_release", req_ready, 1);
      step();
      req_valid = 0;
      wait_resp("bp2");
      chk("bp2_inst", resp_inst, EBRK);
      chk("bp2_err", resp_err, 0);
      step();

      req_valid = 1; req_addr = BASE + 64'd4; resp_ready = 1;
      ld_we = 1; ld_idx = 10'd1; ld_data = 32'hDEAD_BEEF;
      step();
      req_valid = 0; ld_we = 0;
      wait_resp("coll");
      chk("coll_old", resp_inst, EBRK);
      step();
      fetch_lit("coll_new", BASE + 64'd4, 32'hDEAD_BEEF, 0, 10);

      req_valid = 1; req_addr = BASE + 64'd8;
      step();
      req_valid = 0;
      load(2, 32'h1111_1111);
      chk("latched_valid", resp_valid, 1);
      chk("latched_inst", resp_inst, 32'h00A0_0593);
      step();

      req_valid = 1; req_addr = BASE;
      step();
      req_valid = 0; rst = 0;
      step();
      chk("midrst_ready", req_ready, 1);
      chk("midrst_valid", resp_valid, 0);
      chk("midrst_cnt", fetch_cnt, 0);
      rst = 1;
      fetch_lit("refetch", BASE, 32'h0000_0513, 0, 1);

      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 199) != 0);
         req_valid  = ($urandom_range(0, 2) != 0);
         resp_ready = ($urandom_range(0, 3) != 0);
         req_addr   = rand_addr();
         ld_we      = ($urandom_range(0, 5) == 0);
         ld_idx     = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
         ld_data    = $urandom;
         step();
      end
      rst = 1; req_valid = 0; resp_ready = 1; ld_we = 0;
      step();
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the core's fetch interface (pc out, inst in).
- Accepts one fetch request per transaction through a valid/ready handshake.
- Returns the 32-bit instruction after a fixed, parameterised latency, and flags misaligned or out-of-range fetches.
- A separate loader write port preloads the program image before and during simulation.

Parameters:
- ADDR_W, 64, fetch address width (matches core pc width).
- DEPTH_WORDS, 1024, number of 32-bit instruction words stored; power of two.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address of instruction (core pc).
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_inst  out  32  fetched instruction.
- resp_err  out  1  1 = misaligned or out-of-range fetch.
- ld_we  in  1  loader write enable.
- ld_idx  in  log2(DEPTH_WORDS)  loader word index.
- ld_data  in  32  loader write data.
- fetch_cnt  out  32  count of completed responses.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, req_ready=1, resp_valid=0, resp_inst=0, resp_err=0, fetch_cnt=0, latency counter=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T, the responder latches addr, computes err, and reads the word (read-at-accept).
  - counter loads LATENCY-1; next state is WAIT, or RESP directly if LATENCY==1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter==0 the next state is RESP.
  - resp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_inst and resp_err stay stable while resp_ready==0, for any number of cycles.
  - On resp_valid&&resp_ready: fetch_cnt increments (wraps 0xFFFF_FFFF->0), next state is IDLE, resp_valid drops the next cycle.
- No request is accepted in WAIT or RESP; req_addr is ignored there.
- Throughput: at most one fetch per LATENCY+1 cycles.
- Address check at accept:
  - misaligned: req_addr[1:0]!=0;
  - out-of-range: req_addr<BASE_ADDR or req_addr>=BASE_ADDR+4*DEPTH_WORDS.
  - Either condition gives resp_err=1 and resp_inst=32'h0010_0073 (ebreak), so the core halts the simulation.
  - Otherwise: index=(req_addr-BASE_ADDR)>>2, resp_err=0, resp_inst=mem[index].
- Arithmetic: the range check uses full ADDR_W unsigned compare, with no truncation before the compare.
- Loader:
  - ld_we writes mem[ld_idx]=ld_data at the edge, in any state, and is also honoured during reset.
  - A write to the same index in the accept cycle does not affect that fetch (old data returned).
  - The written value is visible to requests accepted on later cycles.
  - A write to a word already latched for a pending response does not change resp_inst.
- Reset mid-operation: any state goes to IDLE. The pending response is dropped without a handshake, and fetch_cnt is not incremented.
- Unwritten words read as undefined; benches must load before fetching.

Test Plan:
- Load mem[0]=32'h0000_0513, mem[1]=32'h0010_0073. Fetch 0x8000_0000 with resp_ready=1 -> resp_valid exactly 2 cycles after accept, resp_inst=32'h0000_0513, resp_err=0, fetch_cnt=1.
- Fetch 0x8000_0002 -> resp_err=1, resp_inst=32'h0010_0073. Fetch 0x8000_1000 (DEPTH 1024) -> resp_err=1. Fetch 0x7FFF_FFFC -> resp_err=1.
- Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_inst stable, req_ready=0, a second req_valid is not accepted. Release -> IDLE next cycle, then the second request is accepted.
- Same cycle as accept of 0x8000_0004, ld_we writes mem[1]=32'hDEAD_BEEF -> response returns the old 32'h0010_0073. The next fetch of 0x8000_0004 returns 32'hDEAD_BEEF.
- Drive rst=0 during WAIT -> next cycle req_ready=1, resp_valid=0, fetch_cnt=0; mem[0] still 32'h0000_0513 on refetch.
- LATENCY=1 build: back-to-back fetches with resp_ready=1 -> resp_valid one cycle after each accept, one fetch every 2 cycles.
